// File: rtl/key_tx_queue.sv
// Keypad press FIFO feeding uart_tx with ASCII digits,
// optionally framed by CR/LF, with a sticky overflow flag.
module key_tx_queue #(
  parameter int FIFO_DEPTH   = 8,
  parameter bit SEND_CRLF    = 1'b1,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [3:0]                    key_value,
  input  logic                          key_valid,
  input  logic                          tx_busy,
  input  logic                          clr_overflow,
  output logic                          tx_start,
  output logic [7:0]                    tx_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMAX = TW'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE,
    NEXT
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [3:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [TW-1:0]   timer_q;
  logic [1:0]      seq_q;
  logic            kv_q;
  logic            push;
  logic            wr;
  logic            drop;
  logic            pop;
  logic            start;
  logic            crlf;

  function automatic logic [7:0] to_ascii(input logic [3:0] k);
    if (k < 4'd10) return {4'h3, k};
    else           return 8'h37 + {4'h0, k};
  endfunction

  assign push = key_valid & ~kv_q;
  assign wr   = push & ((fifo_count != FULL) | pop);
  assign drop = push & (fifo_count == FULL) & ~pop;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    start   = 1'b0;
    crlf    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fifo_count != '0 && !tx_busy) begin
          pop     = 1'b1;
          start   = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy || timer_q == TMAX)
          state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy)
          state_d = (SEND_CRLF && seq_q < 2'd2) ? NEXT : IDLE;
      end
      NEXT: begin
        crlf    = 1'b1;
        start   = 1'b1;
        state_d = WAIT_BUSY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kv_q     <= 1'b0;
      timer_q  <= '0;
      seq_q    <= 2'd0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      kv_q     <= key_valid;
      tx_start <= start;
      // timer is 1 in the strobe cycle, so TMAX means
      // BUSY_TIMEOUT cycles have elapsed since tx_start
      if (start)
        timer_q <= TW'(1);
      else if (state_q == WAIT_BUSY && timer_q != TMAX)
        timer_q <= timer_q + TW'(1);
      if (pop) begin
        tx_data <= to_ascii(mem[rd_ptr]);
        seq_q   <= 2'd0;
      end else if (crlf) begin
        tx_data <= (seq_q == 2'd0) ? 8'h0D : 8'h0A;
        seq_q   <= seq_q + 2'd1;
      end
      if (drop)
        overflow <= 1'b1;
      else if (clr_overflow)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= 4'h0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= key_value;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_key_tx_queue.sv
// Directed bench for key_tx_queue: CR/LF instance plus
// a digit-only instance, with a simple uart_tx busy model.
module tb_key_tx_queue;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_value;
  logic       kv;
  logic       sel;
  logic       force_busy;
  logic       model_en;
  logic       clr_a;
  logic       clr_b;

  logic       kv_a, kv_b;
  logic       busy_a, busy_b;
  logic       start_a, start_b;
  logic [7:0] data_a, data_b;
  logic [3:0] cnt_a, cnt_b;
  logic       ovf_a, ovf_b;

  int bcnt_a;
  int bcnt_b;
  int viol;
  int cyc;
  int total;
  int passes;
  logic [7:0] log_a[$];
  logic [7:0] log_b[$];
  int         cyc_a[$];

  assign kv_a   = kv & ~sel;
  assign kv_b   = kv & sel;
  assign busy_a = force_busy | (bcnt_a != 0);
  assign busy_b = (bcnt_b != 0);

  key_tx_queue u_a (
    .clk(clk), .rst_n(rst_n),
    .key_value(key_value), .key_valid(kv_a),
    .tx_busy(busy_a), .clr_overflow(clr_a),
    .tx_start(start_a), .tx_data(data_a),
    .fifo_count(cnt_a), .overflow(ovf_a)
  );

  key_tx_queue #(.SEND_CRLF(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .key_value(key_value), .key_valid(kv_b),
    .tx_busy(busy_b), .clr_overflow(clr_b),
    .tx_start(start_b), .tx_data(data_b),
    .fifo_count(cnt_b), .overflow(ovf_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx stand-in and strobe logger
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_a = 0;
      bcnt_b = 0;
    end else begin
      if (start_a) begin
        if (busy_a) viol++;
        log_a.push_back(data_a);
        cyc_a.push_back(cyc);
        if (model_en) bcnt_a = 20;
      end else if (bcnt_a != 0) begin
        bcnt_a--;
      end
      if (start_b) begin
        if (busy_b) viol++;
        log_b.push_back(data_b);
        bcnt_b = 4;
      end else if (bcnt_b != 0) begin
        bcnt_b--;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] la(input int i);
    if (i < log_a.size()) return {24'h0, log_a[i]};
    return 32'hDEAD;
  endfunction

  function automatic logic [31:0] lb(input int i);
    if (i < log_b.size()) return {24'h0, log_b[i]};
    return 32'hDEAD;
  endfunction

  function automatic int ca(input int i);
    if (i < cyc_a.size()) return cyc_a[i];
    return 0;
  endfunction

  function automatic logic [31:0] asc(input int k);
    if (k < 10) return 32'(32'h30 + k);
    return 32'(32'h37 + k);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] v, input int hold,
                       input int gap);
    key_value = v;
    kv = 1'b1;
    cycles(hold);
    kv = 1'b0;
    cycles(gap);
  endtask

  task automatic wait_a(input int n, input int budget,
                        input string tag);
    int k;
    k = 0;
    while (log_a.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(log_a.size() >= n), 32'd1);
  endtask

  initial begin
    int n0;
    int k;
    cyc = 0;
    total = 0;
    passes = 0;
    viol = 0;
    rst_n = 1'b0;
    kv = 1'b0;
    sel = 1'b0;
    key_value = 4'h0;
    force_busy = 1'b0;
    model_en = 1'b1;
    clr_a = 1'b0;
    clr_b = 1'b0;
    cycles(3);
    chk("rst_start", 32'(start_a), 32'd0);
    chk("rst_data", 32'(data_a), 32'h00);
    chk("rst_count", 32'(cnt_a), 32'd0);
    chk("rst_ovf", 32'(ovf_a), 32'd0);
    rst_n = 1'b1;
    cycles(2);

    // single press, held long
    log_a.delete();
    key_value = 4'hA;
    kv = 1'b1;
    @(negedge clk);
    chk("lat_count1", 32'(cnt_a), 32'd1);
    chk("lat_nostart", 32'(start_a), 32'd0);
    @(negedge clk);
    chk("lat_start", 32'(start_a), 32'd1);
    chk("lat_data", 32'(data_a), 32'h41);
    chk("lat_count0", 32'(cnt_a), 32'd0);
    cycles(48);
    kv = 1'b0;
    wait_a(3, 300, "single_wait");
    cycles(40);
    chk("single_n", 32'(log_a.size()), 32'd3);
    chk("single_c0", la(0), 32'h41);
    chk("single_c1", la(1), 32'h0D);
    chk("single_c2", la(2), 32'h0A);
    chk("single_cnt", 32'(cnt_a), 32'd0);

    // digit map on the digit-only instance
    sel = 1'b1;
    log_b.delete();
    for (int i = 0; i < 16; i++)
      press(4'(i), 2, 4);
    k = 0;
    while (log_b.size() < 16 && k < 400) begin
      @(negedge clk);
      k++;
    end
    cycles(20);
    chk("map_n", 32'(log_b.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("map_%0d", i), lb(i), asc(i));
    chk("map_ovf", 32'(ovf_b), 32'd0);
    sel = 1'b0;

    // burst while busy, then drain
    log_a.delete();
    force_busy = 1'b1;
    for (int i = 1; i <= 10; i++)
      press(4'(i), 1, 2);
    chk("burst_cnt", 32'(cnt_a), 32'd8);
    chk("burst_ovf", 32'(ovf_a), 32'd1);
    force_busy = 1'b0;
    wait_a(24, 1500, "burst_wait");
    cycles(40);
    chk("burst_n", 32'(log_a.size()), 32'd24);
    for (int i = 0; i < 8; i++)
      chk($sformatf("burst_k%0d", i), la(3 * i), asc(i + 1));
    chk("burst_cr", la(1), 32'h0D);
    chk("burst_lf", la(2), 32'h0A);
    chk("burst_sticky", 32'(ovf_a), 32'd1);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    chk("burst_clr", 32'(ovf_a), 32'd0);
    chk("burst_cnt0", 32'(cnt_a), 32'd0);

    // press lands in the pop cycle of a full FIFO
    log_a.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 8; i++)
      press(4'(i), 1, 2);
    chk("pp_full", 32'(cnt_a), 32'd8);
    force_busy = 1'b0;
    key_value = 4'hC;
    kv = 1'b1;
    @(negedge clk);
    kv = 1'b0;
    chk("pp_cnt", 32'(cnt_a), 32'd8);
    chk("pp_ovf", 32'(ovf_a), 32'd0);
    chk("pp_start", 32'(start_a), 32'd1);
    chk("pp_data", 32'(data_a), 32'h30);
    wait_a(27, 1800, "pp_wait");
    cycles(40);
    chk("pp_k7", la(21), 32'h37);
    chk("pp_kC", la(24), 32'h43);
    chk("pp_cnt0", 32'(cnt_a), 32'd0);

    // busy never rises
    model_en = 1'b0;
    log_a.delete();
    cyc_a.delete();
    press(4'h5, 2, 2);
    wait_a(3, 200, "to_wait");
    cycles(30);
    chk("to_n", 32'(log_a.size()), 32'd3);
    chk("to_c0", la(0), 32'h35);
    chk("to_c1", la(1), 32'h0D);
    chk("to_c2", la(2), 32'h0A);
    chk("to_gap1", 32'(ca(1) - ca(0) >= 16), 32'd1);
    chk("to_gap2", 32'(ca(2) - ca(1) >= 16), 32'd1);

    // reset during the digit strobe with keys queued
    model_en = 1'b1;
    force_busy = 1'b1;
    for (int i = 0; i < 3; i++)
      press(4'(i + 1), 1, 2);
    chk("rm_cnt3", 32'(cnt_a), 32'd3);
    force_busy = 1'b0;
    k = 0;
    while (!start_a && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rm_strobe", 32'(start_a), 32'd1);
    chk("rm_digit", 32'(data_a), 32'h31);
    #1 rst_n = 1'b0;
    #1;
    chk("rm_start", 32'(start_a), 32'd0);
    chk("rm_data", 32'(data_a), 32'h00);
    chk("rm_count", 32'(cnt_a), 32'd0);
    chk("rm_ovf", 32'(ovf_a), 32'd0);
    cycles(2);
    rst_n = 1'b1;
    n0 = log_a.size();
    cycles(150);
    chk("rm_quiet", 32'(log_a.size()), 32'(n0));
    press(4'h7, 2, 2);
    wait_a(n0 + 3, 300, "rm_wait");
    cycles(30);
    chk("rm_n", 32'(log_a.size()), 32'(n0 + 3));
    chk("rm_new", la(n0), 32'h37);
    chk("rm_cr", la(n0 + 1), 32'h0D);
    chk("rm_lf", la(n0 + 2), 32'h0A);

    chk("no_start_busy", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
